// File: rtl/cache_memory_assoc.sv
// N-way set-associative tag/data store with age-based LRU replacement,
// one-cycle registered lookup and a hardware invalidate sweep.
//
// state   | meaning
// S_INIT  | sweeping sets 0..NUM_SETS-1, clearing valid/dirty and resetting ages
// S_READY | accepting one lookup/write per cycle
module cache_memory_assoc #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 256,
  parameter int CACHE_SIZE = 65536,
  parameter int WAYS       = 2,
  localparam int NUM_SETS     = CACHE_SIZE * 8 / BLOCK_SIZE / WAYS,
  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE / DATA_WIDTH),
  localparam int INDEX_WIDTH  = $clog2(NUM_SETS),
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  localparam int WAY_WIDTH    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_en,
  input  logic [BLOCK_SIZE-1:0] data_write,
  input  logic                  dirty_write,
  output logic                  resp_valid,
  output logic                  hit,
  output logic [BLOCK_SIZE-1:0] data_read,
  output logic                  dirty_read,
  output logic                  victim_valid,
  output logic [TAG_WIDTH-1:0]  victim_tag,
  output logic [WAY_WIDTH-1:0]  victim_way,
  output logic                  busy
);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;

  // Storage is never reset; only the sweep clears valid/dirty and ages.
  logic [WAYS-1:0]       arr_valid_q [NUM_SETS];
  logic [WAYS-1:0]       arr_dirty_q [NUM_SETS];
  logic [TAG_WIDTH-1:0]  arr_tag_q   [NUM_SETS][WAYS];
  logic [BLOCK_SIZE-1:0] arr_line_q  [NUM_SETS][WAYS];
  logic [WAY_WIDTH-1:0]  arr_age_q   [NUM_SETS][WAYS];

  logic                  resp_valid_q, hit_q, dirty_read_q, victim_valid_q;
  logic [BLOCK_SIZE-1:0] data_read_q;
  logic [TAG_WIDTH-1:0]  victim_tag_q;
  logic [WAY_WIDTH-1:0]  victim_way_q;

  logic [TAG_WIDTH-1:0]   tag_in;
  logic [INDEX_WIDTH-1:0] idx;
  logic                   unused_offset;
  logic                   accept, upd;
  logic                   hit_c, inv_found;
  logic [WAY_WIDTH-1:0]   hit_way, inv_way, lru_way, tgt;
  logic [WAY_WIDTH-1:0]   age_upd [WAYS];

  assign tag_in        = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign idx           = addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_offset = ^addr[OFFSET_WIDTH-1:0];
  assign accept        = req_valid && (state_q == S_READY);
  assign upd           = accept && (write_en || hit_c);

  // State register and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a flush seen in READY restarts the sweep at set 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_INIT: begin
        busy = 1'b1;
        if (cnt_q == INDEX_WIDTH'(NUM_SETS - 1)) state_d = S_READY;
        else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        req_ready = 1'b1;
        if (flush) state_d = S_INIT;
      end
    endcase
  end

  // Tag compare, victim choice and the LRU ages after touching the target way.
  always_comb begin
    hit_c     = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (arr_valid_q[idx][w] && (arr_tag_q[idx][w] == tag_in)) begin
        hit_c   = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!arr_valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_WIDTH'(w);
      end
      if (arr_age_q[idx][w] == WAY_WIDTH'(WAYS - 1)) lru_way = WAY_WIDTH'(w);
    end
    tgt = hit_c ? hit_way : (inv_found ? inv_way : lru_way);
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_WIDTH'(w) == tgt)                          age_upd[w] = '0;
      else if (arr_age_q[idx][w] < arr_age_q[idx][tgt])  age_upd[w] = arr_age_q[idx][w] + WAY_WIDTH'(1);
      else                                               age_upd[w] = arr_age_q[idx][w];
    end
  end

  // Array updates: sweep clears a set per cycle, accesses write the target way.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      arr_valid_q[cnt_q] <= '0;
      arr_dirty_q[cnt_q] <= '0;
      for (int w = 0; w < WAYS; w++) arr_age_q[cnt_q][w] <= WAY_WIDTH'(w);
    end else if (upd) begin
      if (write_en) begin
        arr_valid_q[idx][tgt] <= 1'b1;
        arr_dirty_q[idx][tgt] <= dirty_write;
        arr_tag_q[idx][tgt]   <= tag_in;
        arr_line_q[idx][tgt]  <= data_write;
      end
      for (int w = 0; w < WAYS; w++) arr_age_q[idx][w] <= age_upd[w];
    end
  end

  // Registered response; data fields hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q   <= 1'b0;
      hit_q          <= 1'b0;
      data_read_q    <= '0;
      dirty_read_q   <= 1'b0;
      victim_valid_q <= 1'b0;
      victim_tag_q   <= '0;
      victim_way_q   <= '0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        hit_q          <= hit_c;
        data_read_q    <= arr_line_q[idx][tgt];
        dirty_read_q   <= arr_dirty_q[idx][tgt];
        victim_valid_q <= !hit_c && arr_valid_q[idx][tgt];
        victim_tag_q   <= arr_tag_q[idx][tgt];
        victim_way_q   <= tgt;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign hit          = hit_q;
  assign data_read    = data_read_q;
  assign dirty_read   = dirty_read_q;
  assign victim_valid = victim_valid_q;
  assign victim_tag   = victim_tag_q;
  assign victim_way   = victim_way_q;

endmodule

// File: tb/tb_cache_memory_assoc.sv
// Directed bench for cache_memory_assoc with default parameters
// (1024 sets, 2 ways, tag 15 / index 10 / offset 3).
module tb_cache_memory_assoc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [27:0]  addr = '0;
  logic         write_en = 1'b0;
  logic [255:0] data_write = '0;
  logic         dirty_write = 1'b0;
  logic         resp_valid, hit, dirty_read, victim_valid, busy;
  logic [255:0] data_read;
  logic [14:0]  victim_tag;
  logic [0:0]   victim_way;

  int tests_run = 0;
  int tests_failed = 0;

  cache_memory_assoc dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .addr(addr),
    .write_en(write_en), .data_write(data_write), .dirty_write(dirty_write),
    .resp_valid(resp_valid), .hit(hit), .data_read(data_read),
    .dirty_read(dirty_read), .victim_valid(victim_valid),
    .victim_tag(victim_tag), .victim_way(victim_way), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk_addr(input logic [14:0] t, input logic [9:0] i);
    return {t, i, 3'b101};
  endfunction

  // One request accepted at the next rising edge; response visible on return.
  task automatic do_req(input logic wr, input logic [27:0] a, input logic [255:0] d,
                        input logic dw, input logic fl);
    @(negedge clk);
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; write_en = wr; addr = a; data_write = d; dirty_write = dw; flush = fl;
    @(posedge clk);
    #1;
    req_valid = 1'b0; write_en = 1'b0; flush = 1'b0;
    chk("resp_valid", resp_valid, 1'b1);
  endtask

  // Counts rising edges until req_ready, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  localparam logic [255:0] L_A = {8{32'hA5A5_0001}};
  localparam logic [255:0] L_B = {8{32'h5A5A_0002}};
  localparam logic [255:0] L_C = {8{32'h1234_5678}};
  localparam logic [255:0] L_X = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] L_Y = {8{32'h0BAD_F00D}};
  localparam logic [255:0] L_Z = {8{32'hCAFE_0003}};

  initial begin
    int n;
    #12;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_data_read", data_read, '0);
    chk("rst_victim", {dirty_read, victim_valid, victim_tag, victim_way}, '0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_cycles", 256'(n), 256'd1024);
    chk("ready_busy", busy, 1'b0);

    // Any read after the sweep misses into an invalid way 0.
    do_req(1'b0, mk_addr(15'h1ABC, 10'd77), '0, 1'b0, 1'b0);
    chk("cold_hit", hit, 1'b0);
    chk("cold_vvalid", victim_valid, 1'b0);
    chk("cold_vway", victim_way, 1'b0);

    // Write then read 0x0001238 (tag 0, index 0x247), back-to-back.
    do_req(1'b1, 28'h0001238, L_C, 1'b1, 1'b0);
    chk("wr_miss_hit", hit, 1'b0);
    do_req(1'b0, 28'h0001238, '0, 1'b0, 1'b0);
    chk("rd_hit", hit, 1'b1);
    chk("rd_data", data_read, L_C);
    chk("rd_dirty", dirty_read, 1'b1);
    chk("rd_hit_vvalid", victim_valid, 1'b0);

    // Fill index 5 with A then B, touch A, then miss on C evicts B.
    do_req(1'b1, mk_addr(15'h00A, 10'd5), L_A, 1'b0, 1'b0);
    chk("fillA_way", victim_way, 1'b0);
    do_req(1'b1, mk_addr(15'h00B, 10'd5), L_B, 1'b0, 1'b0);
    chk("fillB_way", victim_way, 1'b1);
    chk("fillB_hit", hit, 1'b0);
    do_req(1'b0, mk_addr(15'h00A, 10'd5), '0, 1'b0, 1'b0);
    chk("readA_hit", hit, 1'b1);
    chk("readA_way", victim_way, 1'b0);
    chk("readA_data", data_read, L_A);
    do_req(1'b0, mk_addr(15'h00C, 10'd5), '0, 1'b0, 1'b0);
    chk("readC_hit", hit, 1'b0);
    chk("readC_vway", victim_way, 1'b1);
    chk("readC_vtag", victim_tag, 15'h00B);
    chk("readC_vvalid", victim_valid, 1'b1);
    chk("readC_data", data_read, L_B);
    // Read miss must not disturb the set: A still hits.
    do_req(1'b0, mk_addr(15'h00A, 10'd5), '0, 1'b0, 1'b0);
    chk("readA2_hit", hit, 1'b1);

    // Dirty victim report at index 9.
    do_req(1'b1, mk_addr(15'h0D1, 10'd9), L_X, 1'b1, 1'b0);
    do_req(1'b1, mk_addr(15'h0D2, 10'd9), L_Y, 1'b0, 1'b0);
    do_req(1'b1, mk_addr(15'h0D3, 10'd9), L_Z, 1'b0, 1'b0);
    chk("evict_hit", hit, 1'b0);
    chk("evict_way", victim_way, 1'b0);
    chk("evict_dirty", dirty_read, 1'b1);
    chk("evict_data", data_read, L_X);
    chk("evict_vtag", victim_tag, 15'h0D1);
    chk("evict_vvalid", victim_valid, 1'b1);
    do_req(1'b0, mk_addr(15'h0D3, 10'd9), '0, 1'b0, 1'b0);
    chk("newD3_hit", hit, 1'b1);
    chk("newD3_data", data_read, L_Z);
    chk("newD3_dirty", dirty_read, 1'b0);

    // Output hold while idle.
    @(posedge clk);
    #1;
    chk("hold_resp_valid", resp_valid, 1'b0);
    chk("hold_data", data_read, L_Z);

    // Write together with flush: write answers, sweep follows.
    do_req(1'b1, mk_addr(15'h0EE, 10'd5), L_A, 1'b1, 1'b1);
    chk("flush_wr_hit", hit, 1'b0);
    chk("flush_busy", busy, 1'b1);
    chk("flush_ready", req_ready, 1'b0);
    wait_ready(n);
    chk("flush_sweep_cycles", 256'(n), 256'd1024);
    do_req(1'b0, 28'h0001238, '0, 1'b0, 1'b0);
    chk("postflush_hit1", hit, 1'b0);
    chk("postflush_vvalid1", victim_valid, 1'b0);
    do_req(1'b0, mk_addr(15'h0EE, 10'd5), '0, 1'b0, 1'b0);
    chk("postflush_hit2", hit, 1'b0);
    do_req(1'b0, mk_addr(15'h00A, 10'd5), '0, 1'b0, 1'b0);
    chk("postflush_hit3", hit, 1'b0);

    // Flush, then async reset at sweep set 300.
    do_req(1'b0, mk_addr(15'h00A, 10'd5), '0, 1'b0, 1'b1);
    repeat (300) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_ready", req_ready, 1'b0);
    chk("midrst_resp", {resp_valid, hit, dirty_read, victim_valid, victim_tag, victim_way}, '0);
    chk("midrst_data", data_read, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    chk("midrst_sweep_cycles", 256'(n), 256'd1024);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_memory_assoc.md
# cache_memory_assoc

Parametrised N-way set-associative tag/data store for the DDR-backed cache: the next generation of the direct-mapped cache array. It adds configurable associativity, age-based LRU replacement with victim reporting, a registered one-cycle lookup with valid/ready handshake, and a hardware invalidate sweep after reset or on flush. It sits between the cache controller FSM and the DDR fill/writeback path.

## Interface
- ADDR_WIDTH, 28, word address width
- DATA_WIDTH, 32, word width in bits
- BLOCK_SIZE, 256, line width in bits
- CACHE_SIZE, 65536, total capacity in bytes
- WAYS, 2, associativity; power of two, 1..8
- Derived:
  - NUM_SETS = CACHE_SIZE*8/BLOCK_SIZE/WAYS
  - OFFSET_WIDTH = log2(BLOCK_SIZE/DATA_WIDTH)
  - INDEX_WIDTH = log2(NUM_SETS)
  - TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH
  - WAY_WIDTH = max(1, log2(WAYS))
  - Defaults give 1024 sets, tag 15, index 10, offset 3.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  single-cycle pulse; invalidate all lines
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- addr  in  ADDR_WIDTH  tag|index|offset; offset ignored
- write_en  in  1  request is a line write (fill or update)
- data_write  in  BLOCK_SIZE  line to write
- dirty_write  in  1  dirty bit to store
- resp_valid  out  1  one-cycle pulse, response for the previous accepted request
- hit  out  1  tag matched a valid way
- data_read  out  BLOCK_SIZE  hit-way line on hit, victim line on miss
- dirty_read  out  1  dirty bit of the same line
- victim_valid  out  1  victim line was valid (miss only)
- victim_tag  out  TAG_WIDTH  victim tag (miss only)
- victim_way  out  WAY_WIDTH  way selected: hit way or victim way
- busy  out  1  invalidate sweep in progress

## Operation
- **Storage per way per set:** valid, dirty, tag, line. Each set also holds one age value per way (WAY_WIDTH bits); ages in a set are always a permutation of 0..WAYS-1.
- **States:**
  - INIT: sweep in progress; req_ready=0, busy=1.
  - READY: req_ready=1, busy=0.
- **Sweep:** set counter runs 0..NUM_SETS-1, one set per cycle. For each set it clears all valid and dirty bits and sets age[w]=w. After the set NUM_SETS-1 cycle the block goes to READY.
- **Entering INIT:**
  - Reset always enters INIT with the counter at 0.
  - flush sampled in READY enters INIT on the next cycle.
  - flush during INIT is ignored.
  - A request and flush in the same READY cycle: the request is accepted and completes normally, then the sweep starts.
  - Flush is invalidate-only; no writeback is performed. The controller drains dirty lines first.
- **Lookup:** in the accept cycle the set is read combinationally and all ways are compared. Results are registered and appear with resp_valid in the next cycle.
- **Victim selection** (when there is no hit): lowest-numbered invalid way; otherwise the way with age WAYS-1.
- **Read hit:** returns the hit way's line and dirty bit; victim_valid=0; LRU is updated.
- **Read miss:** returns the victim's line, dirty bit, tag, valid flag and way. No state changes.
- **Write:**
  - The target is the hit way if the tag matches, else the victim way.
  - Stores {data_write, tag, dirty_write, valid=1} and updates LRU.
  - Response reports the pre-write contents of the target way (hit/victim fields as for a read), so a fill doubles as an eviction report.
- **LRU update for accessed way a:** every way with age < age[a] increments; age[a] becomes 0.
- **WAYS=1:** victim is always way 0; ages are constant 0.

## Timing
- **Reset values:**
  - req_ready=0, busy=1, resp_valid=0, hit=0, data_read=0, dirty_read=0, victim_valid=0, victim_tag=0, victim_way=0.
  - Array contents are not reset; only the sweep clears valid and dirty.
- **Reset to ready:** req_ready rises exactly NUM_SETS cycles after rst_n deassertion (first sweep edge counted).
- **Latency:** one cycle from accept to resp_valid. Throughput is one request per cycle.
- **Back-to-back requests:** a write accepted in cycle t is visible to a request accepted in t+1, including same set and same way; there is no bypass hazard.
- **Output hold:** data outputs hold their last value when resp_valid=0.
- **Reset mid-sweep or mid-request:** asynchronously returns all outputs to reset values. A pending resp_valid is dropped and the sweep restarts at set 0.

## Test plan
- **Reset sweep:** release rst_n with default params -> busy=1, req_ready=0 for exactly 1024 cycles, then req_ready=1; a read of any address returns hit=0, victim_valid=0, victim_way=0.
- **Write then read:** write addr 0x0001238 with line L, dirty_write=1 -> next-cycle resp hit=0; a read of the same addr then gives hit=1, data_read=L, dirty_read=1.
- **Fill and eviction:** WAYS=2, write tags A then B into index 5, read A, then read tag C at index 5 -> hit=0, victim_way = way holding B, victim_tag=B, victim_valid=1.
- **Dirty victim report:** fill both ways of a set, first dirty, then write-miss a new tag -> response shows dirty_read=1 and the old line; a later read of the new tag hits.
- **Flush with request:** assert flush with a write in the same cycle -> the write gets a response, busy rises the next cycle for 1024 cycles, and afterwards all reads miss.
- **Async reset mid-sweep:** assert rst_n low at sweep set 300 -> outputs go to reset values immediately; req_ready rises 1024 cycles after release.
